// File: rtl/edp_diag_snap_pkg.sv
// Shared types and constants for the EDP diagnostic snapshot sequencer.
// The optional parity bit is enabled by the macro EDP_DIAG_SNAP_PARITY_EN.
package edp_diag_snap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        CAPTURE,
        NEXT,
        DONE
    } snapState_t;

    // EDP diagnostic read selects, in the order the sequencer walks them.
    localparam logic [2:0] DIAG_AR  = 3'd0;
    localparam logic [2:0] DIAG_BR  = 3'd1;
    localparam logic [2:0] DIAG_MQ  = 3'd2;
    localparam logic [2:0] DIAG_FM  = 3'd3;
    localparam logic [2:0] DIAG_BRX = 3'd4;
    localparam logic [2:0] DIAG_ARX = 3'd5;
    localparam logic [2:0] DIAG_ADX = 3'd6;
    localparam logic [2:0] DIAG_AD  = 3'd7;

    // Marker written into an entry whose source never drove the bus.
    localparam logic [35:0] SNAP_TIMEOUT_FILL = 36'o777777777777;

    localparam int EBUS_WIDTH = 36;

`ifdef EDP_DIAG_SNAP_PARITY_EN
    localparam int SNAP_WIDTH = EBUS_WIDTH + 1;
`else
    localparam int SNAP_WIDTH = EBUS_WIDTH;
`endif

    // Even parity over an EBUS word (XOR reduction).
    function automatic logic even_parity(input logic [35:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/edp_diag_snap_buf.sv
// 8-entry snapshot register file: asynchronous clear, one synchronous
// write port, one combinational read port. Width grows to 37 bits when
// EDP_DIAG_SNAP_PARITY_EN is defined (parity in the top bit).
module edp_diag_snap_buf
    import edp_diag_snap_pkg::*;
#(
    parameter int WIDTH = SNAP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [8];

    // Storage: cleared on reset, one word written per capture.
    // NOTE: this array is reset on purpose -- a DTE read before the first
    // snapshot must see zeros -- so it is built from flops, not a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to raddr is not visible until the next cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/edp_diag_snap.sv
// EDP diagnostic snapshot sequencer: on start, walks the eight DIAG read
// selects, waits for the bus to settle, captures each EBUS word into an
// 8-entry buffer, and pulses done. Optional per-entry parity and the
// rdParity port are enabled by the macro EDP_DIAG_SNAP_PARITY_EN.
module edp_diag_snap
    import edp_diag_snap_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        diagReadEn,
    output logic [2:0]  diagSel,
    input  logic        ebusDriving,
    input  logic [35:0] ebusData,
    input  logic [2:0]  rdAddr,
    output logic [35:0] rdData,
`ifdef EDP_DIAG_SNAP_PARITY_EN
    output logic        rdParity,
`endif
    output logic        busy,
    output logic        done,
    output logic        timeoutErr,
    output logic [2:0]  errSel
);

    localparam logic [3:0] SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    snapState_t state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [7:0] timeout_cnt;

    logic                  wr_en;
    logic [35:0]           wr_data;
    logic [SNAP_WIDTH-1:0] wr_word;
    logic [SNAP_WIDTH-1:0] rd_word;

    // Write-port decode: a capture or a timeout fill in CAPTURE, unless aborted.
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = ebusData;
        if (state == CAPTURE && !abort) begin
            if (ebusDriving) begin
                wr_en = 1'b1;
            end else if (timeout_cnt == 8'd0) begin
                wr_en   = 1'b1;
                wr_data = SNAP_TIMEOUT_FILL;
            end
        end
    end

`ifdef EDP_DIAG_SNAP_PARITY_EN
    // Timed-out entries carry parity 0 regardless of the fill pattern.
    assign wr_word  = {(ebusDriving ? even_parity(ebusData) : 1'b0), wr_data};
    assign rdData   = rd_word[35:0];
    assign rdParity = rd_word[36];
`else
    assign wr_word = wr_data;
    assign rdData  = rd_word;
`endif

    edp_diag_snap_buf #(
        .WIDTH (SNAP_WIDTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (idx),
        .wdata (wr_word),
        .raddr (rdAddr),
        .rdata (rd_word)
    );

    // Sequencer FSM with registered outputs; abort overrides every busy state.
    // NOTE: state is updated with non-blocking assignments so all flops see
    // values from the same clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            settle_cnt  <= 4'd0;
            timeout_cnt <= 8'd0;
            diagReadEn  <= 1'b0;
            diagSel     <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeoutErr  <= 1'b0;
            errSel      <= 3'd0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                diagReadEn <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state      <= SELECT;
                            idx        <= 3'd0;
                            timeoutErr <= 1'b0;
                            errSel     <= 3'd0;
                            busy       <= 1'b1;
                        end
                    end
                    SELECT: begin
                        diagSel    <= idx;
                        diagReadEn <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == 4'd0) begin
                            timeout_cnt <= TIMEOUT_LOAD;
                            state       <= CAPTURE;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    CAPTURE: begin
                        if (ebusDriving) begin
                            state <= NEXT;
                        end else if (timeout_cnt == 8'd0) begin
                            timeoutErr <= 1'b1;
                            errSel     <= idx;
                            state      <= NEXT;
                        end else begin
                            timeout_cnt <= timeout_cnt - 8'd1;
                        end
                    end
                    NEXT: begin
                        diagReadEn <= 1'b0;
                        if (idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SELECT;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state      <= IDLE;
                        diagReadEn <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edp_diag_snap.sv
// Directed self-checking bench for edp_diag_snap (SETTLE_CYCLES=2).
// Parity checks are compiled in when EDP_DIAG_SNAP_PARITY_EN is defined.
module tb_edp_diag_snap;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        diagReadEn;
    logic [2:0]  diagSel;
    logic        ebusDriving;
    logic [35:0] ebusData;
    logic [2:0]  rdAddr;
    logic [35:0] rdData;
`ifdef EDP_DIAG_SNAP_PARITY_EN
    logic        rdParity;
`endif
    logic        busy;
    logic        done;
    logic        timeoutErr;
    logic [2:0]  errSel;

    int checks   = 0;
    int failures = 0;

    // Bus source model controls.
    logic [32:0] tag;
    logic        drv_en;
    logic        block_en;
    logic [2:0]  block_sel;
    logic        use_fixed;
    logic [35:0] fixed_val;

    // Sequence monitor results from the last pass.
    logic [2:0] seq [8];
    int         nseq;
    int         bad_gap;
    int         stab_viol;

    always #5 clk = ~clk;

    edp_diag_snap #(
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .diagReadEn  (diagReadEn),
        .diagSel     (diagSel),
        .ebusDriving (ebusDriving),
        .ebusData    (ebusData),
        .rdAddr      (rdAddr),
        .rdData      (rdData),
`ifdef EDP_DIAG_SNAP_PARITY_EN
        .rdParity    (rdParity),
`endif
        .busy        (busy),
        .done        (done),
        .timeoutErr  (timeoutErr),
        .errSel      (errSel)
    );

    // Each source answers with {tag, select} unless it is the blocked one.
    always_comb begin
        ebusData    = use_fixed ? fixed_val : {tag, diagSel};
        ebusDriving = drv_en && !(block_en && diagSel == block_sel);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, monitor selects, wait for done. Optionally pulse a second
    // start at race_cyc (0 = none). Returns cycles from start sample to done.
    task automatic run_pass(input int race_cyc, output int cycles);
        logic       prev_en;
        logic [2:0] prev_sel;
        int         low_run;
        nseq      = 0;
        bad_gap   = 0;
        stab_viol = 0;
        low_run   = 0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        prev_en  = diagReadEn;
        prev_sel = diagSel;
        cycles   = 0;
        while (!done && cycles < 400) begin
            start = (race_cyc != 0 && cycles == race_cyc);
            tick();
            cycles++;
            if (diagReadEn && prev_en && diagSel != prev_sel) stab_viol++;
            if (diagReadEn && !prev_en) begin
                if (nseq < 8) seq[nseq] = diagSel;
                nseq++;
                if (nseq > 1 && low_run != 1) bad_gap++;
                low_run = 0;
            end else if (!diagReadEn && busy) begin
                low_run++;
            end
            prev_en  = diagReadEn;
            prev_sel = diagSel;
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_wait: no done pulse within %0d cycles", cycles);
        end
    endtask

    task automatic check_word(input string name, input logic [2:0] addr, input logic [35:0] exp);
        rdAddr = addr;
        #1;
        checks++;
        if (rdData !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %o expected %o", name, addr, rdData, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rdAddr = 3'd0;
        #12;
        checks++;
        if ({busy, done, diagReadEn, timeoutErr, diagSel, errSel} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b en=%b terr=%b sel=%0d esel=%0d expected all 0",
                     busy, done, diagReadEn, timeoutErr, diagSel, errSel);
        end
        for (int i = 0; i < 8; i++) check_word("reset_buf", 3'(i), 36'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_dump();
        int cyc;
        tag = 33'd0;
        run_pass(0, cyc);
        checks++;
        if (cyc != 41) begin
            failures++;
            $display("FAIL done_latency: got %0d expected 41", cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
        end
        for (int i = 0; i < 8; i++) check_word("basic_buf", 3'(i), 36'(i));
        checks++;
        if (timeoutErr !== 1'b0) begin
            failures++;
            $display("FAIL basic_timeoutErr: got %b expected 0", timeoutErr);
        end
        // Select stability observed during this pass.
        checks++;
        if (nseq != 8) begin
            failures++;
            $display("FAIL sel_words: got %0d enable pulses expected 8", nseq);
        end
        for (int i = 0; i < 8 && i < nseq; i++) begin
            checks++;
            if (seq[i] !== 3'(i)) begin
                failures++;
                $display("FAIL sel_order[%0d]: got %0d expected %0d", i, seq[i], i);
            end
        end
        checks++;
        if (stab_viol != 0 || bad_gap != 0) begin
            failures++;
            $display("FAIL sel_stability: got changes=%0d bad_gaps=%0d expected 0 0", stab_viol, bad_gap);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        tag       = 33'd1;
        block_en  = 1'b1;
        block_sel = 3'd3;
        run_pass(0, cyc);
        block_en = 1'b0;
        checks++;
        if (timeoutErr !== 1'b1 || errSel !== 3'd3) begin
            failures++;
            $display("FAIL timeout_flag: got terr=%b esel=%0d expected 1 3", timeoutErr, errSel);
        end
        for (int i = 0; i < 8; i++)
            check_word("timeout_buf", 3'(i), (i == 3) ? 36'o777777777777 : 36'(8 + i));
`ifdef EDP_DIAG_SNAP_PARITY_EN
        rdAddr = 3'd3;
        #1;
        checks++;
        if (rdParity !== 1'b0) begin
            failures++;
            $display("FAIL timeout_parity: got %b expected 0", rdParity);
        end
`endif
    endtask

    task automatic test_abort();
        int guard;
        int seen_done;
        tag   = 33'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(diagReadEn && diagSel == 3'd4) && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL abort_reach_idx4: got no select 4 expected select 4");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || diagReadEn !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b en=%b expected 0 0", busy, diagReadEn);
        end
        seen_done = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", seen_done);
        end
        checks++;
        if (timeoutErr !== 1'b0) begin
            failures++;
            $display("FAIL abort_terr_cleared: got %b expected 0", timeoutErr);
        end
        for (int i = 0; i < 8; i++)
            check_word("abort_buf", 3'(i), (i < 4) ? 36'(16 + i) : 36'(8 + i));
    endtask

    task automatic test_start_races();
        int cyc;
        tag = 33'd3;
        run_pass(10, cyc);
        checks++;
        if (cyc != 41 || nseq != 8) begin
            failures++;
            $display("FAIL busy_start_ignored: got latency=%0d words=%0d expected 41 8", cyc, nseq);
        end
        for (int i = 0; i < 8; i++) check_word("race_buf", 3'(i), 36'(24 + i));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || diagReadEn !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle: got busy=%b en=%b expected 0 0", busy, diagReadEn);
        end
    endtask

    task automatic test_async_reset();
        tag   = 33'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || diagReadEn !== 1'b1) begin
            failures++;
            $display("FAIL settle_reached: got busy=%b en=%b expected 1 1", busy, diagReadEn);
        end
        rdAddr = 3'd5;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, diagReadEn, timeoutErr, diagSel, errSel} !== 10'b0) begin
            failures++;
            $display("FAIL async_reset_outputs: got busy=%b en=%b sel=%0d expected 0 0 0",
                     busy, diagReadEn, diagSel);
        end
        checks++;
        if (rdData !== 36'd0) begin
            failures++;
            $display("FAIL async_reset_buf: got %o expected 0", rdData);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef EDP_DIAG_SNAP_PARITY_EN
    task automatic test_parity();
        int cyc;
        use_fixed = 1'b1;
        fixed_val = 36'o1;
        run_pass(0, cyc);
        rdAddr = 3'd2;
        #1;
        checks++;
        if (rdParity !== 1'b1 || rdData !== 36'o1) begin
            failures++;
            $display("FAIL parity_odd: got par=%b data=%o expected 1 1", rdParity, rdData);
        end
        fixed_val = 36'o3;
        run_pass(0, cyc);
        rdAddr = 3'd6;
        #1;
        checks++;
        if (rdParity !== 1'b0 || rdData !== 36'o3) begin
            failures++;
            $display("FAIL parity_even: got par=%b data=%o expected 0 3", rdParity, rdData);
        end
        use_fixed = 1'b0;
    endtask
`endif

    initial begin
        tag       = 33'd0;
        drv_en    = 1'b1;
        block_en  = 1'b0;
        block_sel = 3'd0;
        use_fixed = 1'b0;
        fixed_val = 36'd0;
        test_reset();
        test_basic_dump();
        test_timeout();
        test_abort();
        test_start_races();
        test_async_reset();
`ifdef EDP_DIAG_SNAP_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
